// File: rtl/riscvibe_pkg.sv
// Shared types for the RV32I pipeline: pipeline register layouts and the
// memory-stage enums (access width, handshake FSM states, exception causes).
package riscvibe_pkg;

  localparam int MEM_TIMEOUT_DEFAULT = 64;

  // Access width uses the RV32I load/store funct3 encoding.
  typedef enum logic [2:0] {
    MW_B  = 3'b000,
    MW_H  = 3'b001,
    MW_W  = 3'b010,
    MW_BU = 3'b100,
    MW_HU = 3'b101
  } mem_width_e;

  typedef enum logic [2:0] {
    MEM_IDLE  = 3'd0,
    MEM_REQ   = 3'd1,
    MEM_WAIT  = 3'd2,
    MEM_DONE  = 3'd3,
    MEM_DRAIN = 3'd4
  } mem_fsm_e;

  typedef enum logic [1:0] {
    EXC_NONE        = 2'd0,
    EXC_LD_MISALIGN = 2'd1,
    EXC_ST_MISALIGN = 2'd2,
    EXC_BUS_ERR     = 2'd3
  } mem_exc_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [2:0]  funct3;
  } ex_mem_reg_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] mem_read_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_to_reg;
  } mem_wb_reg_t;

  // log2 of the access size in bytes; unknown encodings behave as a word.
  function automatic logic [1:0] width_log2(input logic [2:0] funct3);
    case (funct3)
      MW_B, MW_BU: return 2'd0;
      MW_H, MW_HU: return 2'd1;
      default:     return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, load extraction/extension and misalignment
// detection. Purely combinational.
module lsu_align
  import riscvibe_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [1:0]  size;
  logic [15:0] shifted;

  always_comb begin
    size       = width_log2(funct3);
    shifted    = 16'(load_word >> {addr_lo, 3'b000});
    misaligned = 1'b0;
    wstrb      = 4'b0000;
    wdata      = store_data;
    load_data  = load_word;

    case (size)
      2'd0: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'd1: begin
        misaligned = addr_lo[0];
        wstrb      = 4'b0011 << addr_lo;
        wdata      = {2{store_data[15:0]}};
      end
      default: begin
        misaligned = |addr_lo;
        wstrb      = 4'b1111;
      end
    endcase

    // Loads present no byte enables on the bus.
    if (!is_store) wstrb = 4'b0000;

    case (funct3)
      MW_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      MW_BU:   load_data = {24'b0, shifted[7:0]};
      MW_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      MW_HU:   load_data = {16'b0, shifted[15:0]};
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// RV32I memory-access stage with a variable-latency valid/ready data port,
// pipeline stall generation, misalignment/bus-error exceptions and flush drain.
module mem_stage_hs
  import riscvibe_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT,
  parameter int CNT_W          = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  ex_mem_reg_t       ex_mem_in,
  output mem_wb_reg_t       mem_wb_out,
  output logic              stall,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic [ADDR_W-1:0] dmem_req_addr,
  output logic              dmem_req_we,
  output logic [3:0]        dmem_req_wstrb,
  output logic [31:0]       dmem_req_wdata,
  input  logic              dmem_rsp_valid,
  input  logic [31:0]       dmem_rsp_rdata,
  input  logic              dmem_rsp_err,
  output logic              exc_valid,
  output logic [1:0]        exc_cause
);

  // Handshake: a request transfers on a cycle with dmem_req_valid & dmem_req_ready;
  // once valid is raised it stays up with stable payload until accepted, except
  // that a flush in REQ withdraws it. Exactly one response (dmem_rsp_valid) returns
  // per accepted request, and only one request is ever outstanding.

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  mem_fsm_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      cap_data_q, cap_data_d;
  logic             cap_err_q, cap_err_d;

  logic        is_mem, op, aligned_op, misaligned, timeout_hit;
  logic [31:0] load_data;

  lsu_align u_align (
    .funct3     (ex_mem_in.funct3),
    .addr_lo    (ex_mem_in.alu_result[1:0]),
    .is_store   (ex_mem_in.mem_write),
    .store_data (ex_mem_in.rs2_data),
    .load_word  (cap_data_q),
    .wstrb      (dmem_req_wstrb),
    .wdata      (dmem_req_wdata),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  assign is_mem        = ex_mem_in.mem_read | ex_mem_in.mem_write;
  assign op            = ex_mem_in.valid & is_mem & ~flush;
  assign aligned_op    = op & ~misaligned;
  assign timeout_hit   = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);
  assign dmem_req_addr = {ex_mem_in.alu_result[ADDR_W-1:2], 2'b00};
  assign dmem_req_we   = ex_mem_in.mem_write;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_data_d = cap_data_q;
    cap_err_d  = cap_err_q;

    case (state_q)
      MEM_IDLE: begin
        cnt_d = '0;
        if (aligned_op) state_d = dmem_req_ready ? MEM_WAIT : MEM_REQ;
      end
      MEM_REQ: begin
        if (flush)               state_d = MEM_IDLE;
        else if (dmem_req_ready) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (flush) begin
          // Drain gets a fresh timeout window for the orphaned response.
          cnt_d   = '0;
          state_d = dmem_rsp_valid ? MEM_IDLE : MEM_DRAIN;
        end else if (dmem_rsp_valid) begin
          cap_data_d = dmem_rsp_rdata;
          cap_err_d  = dmem_rsp_err;
          state_d    = MEM_DONE;
        end else if (timeout_hit) begin
          cap_data_d = '0;
          cap_err_d  = 1'b1;
          state_d    = MEM_DONE;
        end
      end
      MEM_DONE: state_d = MEM_IDLE;
      MEM_DRAIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_rsp_valid || timeout_hit) state_d = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_comb begin
    mem_wb_out               = '0;
    mem_wb_out.pc            = ex_mem_in.pc;
    mem_wb_out.alu_result    = ex_mem_in.alu_result;
    mem_wb_out.mem_read_data = load_data;
    mem_wb_out.rd            = ex_mem_in.rd;
    mem_wb_out.reg_write     = ex_mem_in.reg_write;
    mem_wb_out.mem_to_reg    = ex_mem_in.mem_to_reg;
    stall                    = 1'b0;
    dmem_req_valid           = 1'b0;
    exc_valid                = 1'b0;
    exc_cause                = EXC_NONE;

    if (!rst) begin
      case (state_q)
        MEM_IDLE: begin
          dmem_req_valid   = aligned_op;
          stall            = aligned_op;
          mem_wb_out.valid = ex_mem_in.valid & ~flush & ~aligned_op;
          if (op && misaligned) begin
            mem_wb_out.reg_write = 1'b0;
            exc_valid            = 1'b1;
            exc_cause            = ex_mem_in.mem_write ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
          end
        end
        MEM_REQ: begin
          dmem_req_valid = ~flush;
          stall          = 1'b1;
        end
        MEM_WAIT, MEM_DRAIN: stall = 1'b1;
        MEM_DONE: begin
          mem_wb_out.valid = ex_mem_in.valid & ~flush;
          if (cap_err_q) begin
            mem_wb_out.reg_write = 1'b0;
            exc_valid            = ~flush;
            exc_cause            = flush ? EXC_NONE : EXC_BUS_ERR;
          end
        end
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MEM_IDLE;
      cnt_q      <= '0;
      cap_data_q <= '0;
      cap_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_data_q <= cap_data_d;
      cap_err_q  <= cap_err_d;
    end
  end

  // A response with nothing outstanding is a memory-side protocol violation.
  property p_no_stray_rsp;
    @(posedge clk) disable iff (rst)
      dmem_rsp_valid |-> !(state_q inside {MEM_IDLE, MEM_REQ});
  endproperty
  a_no_stray_rsp: assert property (p_no_stray_rsp);

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
Next-generation Memory Access stage for the 5-stage RV32I pipeline. It replaces the fixed single-cycle internal data memory with a variable-latency request/response data-memory port. It also adds:
- pipeline stall generation
- byte-lane steering and load sign/zero extension
- misalignment detection
- response-timeout bus-error reporting
- flush handling, including draining in-flight requests

It sits between the EX/MEM and MEM/WB pipeline registers.

Parameters:
ADDR_W, 32, width of the data-memory address bus (low ADDR_W bits of alu_result are used).
TIMEOUT_CYCLES, 64, number of cycles to wait for a response before declaring a bus error; 0 disables the timeout.
CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter (derived parameter).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  kill the instruction currently in MEM (from hazard unit)
ex_mem_in  in  ex_mem_reg_t  EX/MEM register; held stable by upstream while stall=1
mem_wb_out  out  mem_wb_reg_t  to the MEM/WB register
stall  out  1  freeze IF..EX/MEM; MEM/WB captures a bubble
dmem_req_valid  out  1  request valid
dmem_req_ready  in  1  memory accepts request
dmem_req_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
dmem_req_we  out  1  1 = store
dmem_req_wstrb  out  4  byte enables
dmem_req_wdata  out  32  lane-steered store data
dmem_rsp_valid  in  1  response valid (one per accepted request, in order)
dmem_rsp_rdata  in  32  raw read word
dmem_rsp_err  in  1  bus error on the response
exc_valid  out  1  one-cycle pulse: the exception accompanies the instruction leaving MEM
exc_cause  out  2  0 none, 1 load misaligned, 2 store misaligned, 3 bus error/timeout

Behaviour:
- op = ex_mem_in.valid & (mem_read | mem_write) & ~flush. Only one request is outstanding at any time.
- mem_width uses funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU. Any other value is illegal and is treated as W.
- Misaligned access (H with addr[0]=1; W with addr[1:0]!=0):
  - No request is issued and no stall occurs.
  - mem_wb_out.reg_write is forced to 0.
  - exc_valid=1 with cause 1 (load) or 2 (store), in the same cycle.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE:
  - Non-memory or invalid instruction: passthrough, stall=0, zero added latency.
  - Aligned op: dmem_req_valid=1 combinationally and stall=1. If dmem_req_ready, go to WAIT; otherwise go to REQ.
- REQ: hold the request stable and keep stall=1.
  - dmem_req_ready → WAIT.
  - flush → IDLE with no request issued; the request may be withdrawn only in this state.
- WAIT: stall=1; the timeout counter increments each cycle.
  - rsp_valid → capture rdata/err into a register, go to DONE.
  - Counter reaches TIMEOUT_CYCLES → DONE with err=1.
  - flush → DRAIN.
- DONE: stall=0. mem_wb_out carries the extended load data from the captured register, then → IDLE.
  - If err: reg_write=0, exc_valid=1, cause=3.
- DRAIN: stall=1 and mem_wb_out.valid=0. Wait for rsp_valid (or timeout), discard the response, → IDLE.
- Minimum latency with ready=1 and a response the next cycle: 2 stall cycles. Accept at t0, rsp at t1, DONE at t2. Stores also wait for their write ack.
- Store lanes:
  - B: wstrb = 1<<addr[1:0]; wdata = rs2[7:0] replicated ×4.
  - H: wstrb = 0011<<addr[1:0]; wdata = rs2[15:0] ×2.
  - W: wstrb = 1111.
- Load extract: byte/half selected by addr[1:0], sign-extended (B,H) or zero-extended (BU,HU).
- While stall=1 or in DRAIN: mem_wb_out.valid=0. Other fields pass through from ex_mem_in.
- Reset (synchronous, rst=1):
  - State → IDLE; counter=0; captured data=0.
  - Outputs stall=0, dmem_req_valid=0, exc_valid=0, mem_wb_out.valid=0 during reset.
- A request outstanding at reset is abandoned. The memory is required to be reset by the same rst.
- flush and rsp_valid in the same WAIT cycle: the response is consumed and discarded, → IDLE.
- rsp_valid in IDLE or REQ is a protocol violation; it is ignored. An assertion is required.

Decomposition:
- Package riscvibe_pkg gains:
  - mem_width_e (B/H/W/BU/HU codes)
  - mem_fsm_e (IDLE/REQ/WAIT/DONE/DRAIN)
  - mem_exc_e (cause codes)
  - MEM_TIMEOUT_DEFAULT constant
- One combinational sub-module, lsu_align, holds the wstrb/wdata steering, load extraction and misalignment flags. The FSM, counter and capture register stay in mem_stage_hs.

Test Plan:
- LW addr 0x100; ready=1; rsp at t+1 with rdata 0xDEADBEEF → stall high 2 cycles; mem_wb_out.mem_read_data=0xDEADBEEF, valid=1 at t+2.
- LB addr 0x103, rdata 0x80FF_FF00 → 0xFFFFFF80. LBU same → 0x00000080. LHU addr 0x102 → 0x000080FF.
- SB addr 0x101, rs2=0x1234_56AB; ready low 3 cycles → request held stable with wstrb=0010, wdata=0xABABABAB; stall for 3+2 cycles.
- LW addr 0x102 → no dmem_req_valid, stall=0, reg_write=0, exc_valid=1 with cause 1 in the same cycle.
- TIMEOUT_CYCLES=4, no response → DONE after 4 WAIT cycles with exc cause 3. A later rsp_valid in IDLE fires the assertion.
- flush during WAIT; rsp arrives 2 cycles later → DRAIN, no valid output, response discarded, next ADD passes with zero stall.
